// File: rtl/stream_unpadding.sv
// stream_unpadding: strips the P-element border from a row-major padded
// (R_N+2P) x (C_N+2P) stream and forwards the R_N x C_N interior.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is combinational and depends only on en_unpadding and the
// single output register (free, or draining this cycle). out_valid is held
// until accepted, and out_data/out_last stay stable while stalled.
module stream_unpadding #(
    parameter int In_d_W = 32,
    parameter int R_N    = 3,
    parameter int C_N    = 3,
    parameter int P      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en_unpadding,
    input  logic              in_valid,
    input  logic [In_d_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [In_d_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_done,
    output logic              err_border
);

    localparam int R_N_P = R_N + 2 * P;
    localparam int C_N_P = C_N + 2 * P;
    localparam int RW    = (R_N_P > 1) ? $clog2(R_N_P) : 1;
    localparam int CW    = (C_N_P > 1) ? $clog2(C_N_P) : 1;

    // Row/column bounds of the padded frame and of its interior window.
    localparam logic [RW-1:0] R_LAST     = RW'(R_N_P - 1);
    localparam logic [RW-1:0] R_LO       = RW'(P);
    localparam logic [RW-1:0] R_HI       = RW'(R_N + P);
    localparam logic [RW-1:0] R_OUT_LAST = RW'(R_N + P - 1);
    localparam logic [CW-1:0] C_LAST     = CW'(C_N_P - 1);
    localparam logic [CW-1:0] C_LO       = CW'(P);
    localparam logic [CW-1:0] C_HI       = CW'(C_N + P);
    localparam logic [CW-1:0] C_OUT_LAST = CW'(C_N + P - 1);

    logic [RW-1:0]     r_q, r_d;
    logic [CW-1:0]     c_q, c_d;
    logic              out_valid_q, out_valid_d;
    logic [In_d_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              frame_done_q, frame_done_d;
    logic              err_q, err_d;

    logic accept;
    logic interior;
    logic at_frame_end;

    assign in_ready     = en_unpadding && (!out_valid_q || out_ready);
    assign accept       = in_valid && in_ready;
    assign interior     = (r_q >= R_LO) && (r_q < R_HI) && (c_q >= C_LO) && (c_q < C_HI);
    assign at_frame_end = (r_q == R_LAST) && (c_q == C_LAST);

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign frame_done = frame_done_q;
    assign err_border = err_q;

    // Next-state: position counters, output register load/drain, flags.
    always_comb begin
        r_d          = r_q;
        c_d          = c_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        err_d        = err_q;

        // A drain frees the register; a same-cycle interior load below re-fills it.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (c_q == C_LAST) begin
                c_d = '0;
                r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end

            if (interior) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
                out_last_d  = (r_q == R_OUT_LAST) && (c_q == C_OUT_LAST);
            end else if (in_data != '0) begin
                err_d = 1'b1;
            end

            frame_done_d = at_frame_end;
        end
    end

    // State register: async reset, then synchronous clear with top priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q          <= '0;
            c_q          <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else if (clr) begin
            r_q          <= '0;
            c_q          <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            r_q          <= r_d;
            c_q          <= c_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

endmodule
